// File: rtl/uart_pkg.sv
// Shared UART link constants, baud-timing helpers and receiver state encodings.
package uart_pkg;

  localparam int unsigned UART_CLK_FRQ   = 27_000_000;
  localparam int unsigned UART_BAUD_RATE = 921_600;
  localparam int unsigned DATA_W         = 8;
  localparam int unsigned CNT_W          = 16;
  localparam int unsigned BIT_W          = 3;

  // Clocks per serial bit (integer division, matches the transmitter).
  function automatic int unsigned calc_cycle(input int unsigned clk_frq,
                                             input int unsigned baud_rate);
    return clk_frq / baud_rate;
  endfunction

  // Offset into the start bit at which it is re-checked.
  function automatic int unsigned calc_half(input int unsigned cycle);
    return cycle / 2;
  endfunction

  // Default link timing shared by transmitter and receiver.
  localparam int unsigned UART_CYCLE = calc_cycle(UART_CLK_FRQ, UART_BAUD_RATE);
  localparam int unsigned UART_HALF  = calc_half(UART_CYCLE);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } rx_state_e;

  // 2-of-3 vote over a short sample history.
  function automatic logic maj3(input logic [2:0] v);
    return (v[0] & v[1]) | (v[0] & v[2]) | (v[1] & v[2]);
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-to-consumer byte handshake plus status pulses.
interface uart_rx_if;

  logic [uart_pkg::DATA_W-1:0] rx_data;
  logic                        rx_valid;
  logic                        rx_ack;
  logic                        rx_busy;
  logic                        rx_frame_err;
  logic                        rx_overrun;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ack,
    output rx_busy,
    output rx_frame_err,
    output rx_overrun
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ack,
    input  rx_busy,
    input  rx_frame_err,
    input  rx_overrun
  );

endinterface

// File: rtl/uart_rx_sync_2ff.sv
// Two-flop synchroniser for a single asynchronous bit with a chosen reset value.
module sync_2ff #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  logic meta;

  // Two-stage capture of the asynchronous input.
  always_ff @(posedge clk) begin
    if (reset) begin
      meta <= RST_VAL;
      q    <= RST_VAL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with valid/ack delivery, framing-error and overrun pulses.
// Optional macro UART_RX_MAJORITY_EN: bit decisions use a 2-of-3 vote over
// the last three synchronised samples instead of the raw synchronised line.
module uart_rx
  import uart_pkg::*;
#(
  parameter int unsigned CLK_FRQ   = UART_CLK_FRQ,
  parameter int unsigned BAUD_RATE = UART_BAUD_RATE
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      rx_in,
  uart_rx_if.master rx_bus
);

  localparam int unsigned CYCLE = calc_cycle(CLK_FRQ, BAUD_RATE);
  localparam int unsigned HALF  = calc_half(CYCLE);

  rx_state_e         state;
  logic [CNT_W-1:0]  cycle_cnt;
  logic [BIT_W-1:0]  bit_cnt;
  logic [DATA_W-1:0] shift_reg;
  logic [DATA_W-1:0] data_q;
  logic              valid_q;
  logic              busy_q;
  logic              frame_err_q;
  logic              overrun_q;
  logic              rx_s;
  logic              sample;

  sync_2ff #(
    .RST_VAL (1'b1)
  ) u_sync (
    .clk   (clk),
    .reset (reset),
    .d     (rx_in),
    .q     (rx_s)
  );

`ifdef UART_RX_MAJORITY_EN
  logic [2:0] hist;

  // History of the last three synchronised line values.
  always_ff @(posedge clk) begin
    if (reset) begin
      hist <= 3'b111;
    end else begin
      hist <= {hist[1:0], rx_s};
    end
  end

  assign sample = maj3(hist);
`else
  assign sample = rx_s;
`endif

  // Frame decoder, byte delivery and status pulses.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= S_IDLE;
      cycle_cnt   <= '0;
      bit_cnt     <= '0;
      shift_reg   <= '0;
      data_q      <= '0;
      valid_q     <= 1'b0;
      busy_q      <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
    end else begin
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;

      // Consumer acceptance; a delivery on the same edge overrides this below.
      if (valid_q && rx_bus.rx_ack) begin
        valid_q <= 1'b0;
      end

      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state     <= S_START;
            cycle_cnt <= '0;
            busy_q    <= 1'b1;
          end
        end

        S_START: begin
          if (cycle_cnt == CNT_W'(HALF)) begin
            cycle_cnt <= '0;
            if (!sample) begin
              state   <= S_DATA;
              bit_cnt <= '0;
            end else begin
              state  <= S_IDLE;
              busy_q <= 1'b0;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end

        S_DATA: begin
          if (cycle_cnt == CNT_W'(CYCLE - 1)) begin
            shift_reg <= {sample, shift_reg[DATA_W-1:1]};
            cycle_cnt <= '0;
            if (bit_cnt == BIT_W'(DATA_W - 1)) begin
              state <= S_STOP;
            end else begin
              bit_cnt <= bit_cnt + BIT_W'(1);
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end

        S_STOP: begin
          if (cycle_cnt == CNT_W'(CYCLE - 1)) begin
            cycle_cnt <= '0;
            if (sample) begin
              // Leave at mid-stop so an immediately following start bit is seen.
              state  <= S_IDLE;
              busy_q <= 1'b0;
              if (valid_q && !rx_bus.rx_ack) begin
                overrun_q <= 1'b1;
              end else begin
                data_q  <= shift_reg;
                valid_q <= 1'b1;
              end
            end else begin
              frame_err_q <= 1'b1;
              state       <= S_BREAK;
            end
          end else begin
            cycle_cnt <= cycle_cnt + CNT_W'(1);
          end
        end

        S_BREAK: begin
          // A held-low line must return high before another frame is accepted.
          if (rx_s) begin
            state  <= S_IDLE;
            busy_q <= 1'b0;
          end
        end

        default: begin
          state  <= S_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign rx_bus.rx_data      = data_q;
  assign rx_bus.rx_valid     = valid_q;
  assign rx_bus.rx_busy      = busy_q;
  assign rx_bus.rx_frame_err = frame_err_q;
  assign rx_bus.rx_overrun   = overrun_q;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: frame table plus hand-written latency, overrun,
// break, glitch and reset sequences.
module tb_uart_rx;

  localparam int CYCLE = 29;
  localparam int HALF  = 14;
  localparam int FRAME = 10 * CYCLE;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  logic rx_in = 1'b1;
  logic auto_ack = 1'b0;

  uart_rx_if bus ();

  uart_rx dut (
    .clk    (clk),
    .reset  (reset),
    .rx_in  (rx_in),
    .rx_bus (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  int         fe_cnt   = 0;
  int         ov_cnt   = 0;
  int         rise_cnt = 0;
  int         rise_cyc = 0;
  int         ov_cyc   = 0;
  logic       prev_valid = 1'b0;
  logic [7:0] last_data  = 8'h00;
  logic [7:0] rx_q[$];

  always @(posedge clk) cyc <= cyc + 1;

  // Output monitor, sampled on the falling edge.
  initial begin
    forever begin
      @(negedge clk);
      if (bus.rx_frame_err) fe_cnt++;
      if (bus.rx_overrun) begin
        ov_cnt++;
        ov_cyc = cyc;
      end
      if (bus.rx_valid && !prev_valid) begin
        rise_cnt++;
        rise_cyc  = cyc;
        last_data = bus.rx_data;
        rx_q.push_back(bus.rx_data);
      end
      prev_valid = bus.rx_valid;
    end
  end

  // Consumer: one-cycle ack pulse for each valid byte while auto_ack is set.
  initial begin
    bus.rx_ack = 1'b0;
    forever begin
      @(negedge clk);
      bus.rx_ack = auto_ack && bus.rx_valid && !bus.rx_ack;
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Drive nedges clocks of an 8N1 frame; glitch_k inverts the line for that one edge.
  task automatic send_frame(input logic [7:0] d, input logic stop,
                            input int glitch_k, input int nedges);
    logic [9:0] fr;
    fr = {stop, d, 1'b0};
    for (int k = 1; k <= nedges; k++) begin
      rx_in = fr[4'((k - 1) / CYCLE)] ^ (k == glitch_k);
      tick();
    end
  endtask

  task automatic flush();
    auto_ack = 1'b1;
    repeat (4) tick();
    auto_ack = 1'b0;
    repeat (2) tick();
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_rise;
    logic [7:0] exp_data;
    int         exp_fe;
    int         exp_ov;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int t0, r0, f0, o0, q0;

    vecs[0] = '{8'h55, 1'b1, 1, 8'h55, 0, 0};
    vecs[1] = '{8'hA3, 1'b1, 1, 8'hA3, 0, 0};
    vecs[2] = '{8'h0F, 1'b1, 1, 8'h0F, 0, 0};
    vecs[3] = '{8'h00, 1'b1, 1, 8'h00, 0, 0};
    vecs[4] = '{8'hFF, 1'b1, 1, 8'hFF, 0, 0};
    vecs[5] = '{8'h80, 1'b1, 1, 8'h80, 0, 0};
    vecs[6] = '{8'h01, 1'b1, 1, 8'h01, 0, 0};
    vecs[7] = '{8'hFF, 1'b0, 0, 8'h00, 1, 0};

    // Reset state
    repeat (4) tick();
    check("reset rx_data", 32'(bus.rx_data), 32'h0);
    check("reset rx_valid", 32'(bus.rx_valid), 32'h0);
    check("reset rx_busy", 32'(bus.rx_busy), 32'h0);
    check("reset rx_frame_err", 32'(bus.rx_frame_err), 32'h0);
    check("reset rx_overrun", 32'(bus.rx_overrun), 32'h0);
    reset = 1'b0;
    repeat (3) tick();

    // First-byte latency with ack held low
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    t0 = cyc;
    send_frame(8'h55, 1'b1, 0, FRAME);
    rx_in = 1'b1;
    repeat (4) tick();
    check("lat rises", 32'(rise_cnt - r0), 32'd1);
    check("lat edge", 32'(rise_cyc - t0), 32'd279);
    check("lat data", 32'(bus.rx_data), 32'h55);
    check("lat valid held", 32'(bus.rx_valid), 32'h1);
    check("lat pulses", 32'((fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
    flush();

    // Frame table
    for (int i = 0; i < 8; i++) begin
      r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
      send_frame(vecs[i].data, vecs[i].stop, 0, FRAME);
      rx_in = 1'b1;
      repeat (6) tick();
      check($sformatf("vec%0d rises", i), 32'(rise_cnt - r0), 32'(vecs[i].exp_rise));
      check($sformatf("vec%0d frame_err", i), 32'(fe_cnt - f0), 32'(vecs[i].exp_fe));
      check($sformatf("vec%0d overrun", i), 32'(ov_cnt - o0), 32'(vecs[i].exp_ov));
      check($sformatf("vec%0d valid", i), 32'(bus.rx_valid), 32'(vecs[i].exp_rise));
      check($sformatf("vec%0d busy", i), 32'(bus.rx_busy), 32'd0);
      if (vecs[i].exp_rise != 0)
        check($sformatf("vec%0d data", i), 32'(bus.rx_data), 32'(vecs[i].exp_data));
      flush();
    end

    // Back-to-back frames with the consumer acking
    r0 = rise_cnt; o0 = ov_cnt; q0 = rx_q.size();
    auto_ack = 1'b1;
    send_frame(8'hA3, 1'b1, 0, FRAME);
    send_frame(8'h0F, 1'b1, 0, FRAME);
    rx_in = 1'b1;
    repeat (6) tick();
    auto_ack = 1'b0;
    repeat (2) tick();
    check("b2b rises", 32'(rise_cnt - r0), 32'd2);
    check("b2b byte0", 32'((rx_q.size() > q0) ? rx_q[q0] : 8'hxx), 32'hA3);
    check("b2b byte1", 32'((rx_q.size() > q0 + 1) ? rx_q[q0 + 1] : 8'hxx), 32'h0F);
    check("b2b overrun", 32'(ov_cnt - o0), 32'd0);

    // Overrun: second byte arrives while the first is unacknowledged
    r0 = rise_cnt; o0 = ov_cnt;
    t0 = cyc;
    send_frame(8'h12, 1'b1, 0, FRAME);
    send_frame(8'h34, 1'b1, 0, FRAME);
    rx_in = 1'b1;
    repeat (6) tick();
    check("ovr rises", 32'(rise_cnt - r0), 32'd1);
    check("ovr pulses", 32'(ov_cnt - o0), 32'd1);
    check("ovr edge", 32'(ov_cyc - t0), 32'(279 + FRAME));
    check("ovr data kept", 32'(bus.rx_data), 32'h12);
    check("ovr valid", 32'(bus.rx_valid), 32'h1);
    flush();

    // Framing error followed by a held-low line
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'hFF, 1'b0, 0, FRAME);
    repeat (5 * CYCLE) tick();
    check("brk frame_err", 32'(fe_cnt - f0), 32'd1);
    check("brk valid", 32'(bus.rx_valid), 32'h0);
    check("brk state", 32'(3'(dut.state)), 32'd4);
    check("brk busy", 32'(bus.rx_busy), 32'h1);
    rx_in = 1'b1;
    repeat (5) tick();
    check("brk released", 32'(bus.rx_busy), 32'h0);
    send_frame(8'h81, 1'b1, 0, FRAME);
    rx_in = 1'b1;
    repeat (6) tick();
    check("brk next rises", 32'(rise_cnt - r0), 32'd1);
    check("brk next data", 32'(bus.rx_data), 32'h81);
    check("brk single err", 32'(fe_cnt - f0), 32'd1);
    flush();

    // Short low glitch aborts in S_START
    r0 = rise_cnt; f0 = fe_cnt;
    rx_in = 1'b0;
    repeat (5) tick();
    rx_in = 1'b1;
    repeat (5) tick();
    check("glitch busy mid", 32'(bus.rx_busy), 32'h1);
    repeat (4 + HALF + 1 - 10) tick();
    check("glitch busy end", 32'(bus.rx_busy), 32'h0);
    check("glitch valid", 32'(bus.rx_valid), 32'h0);
    check("glitch no byte", 32'((rise_cnt - r0) + (fe_cnt - f0)), 32'd0);

    // Reset in the middle of a frame
    repeat (4) tick();
    r0 = rise_cnt; f0 = fe_cnt; o0 = ov_cnt;
    send_frame(8'hC3, 1'b1, 0, 5 * CYCLE);
    reset = 1'b1;
    rx_in = 1'b1;
    repeat (4) tick();
    reset = 1'b0;
    repeat (4) tick();
    check("rst pulses", 32'((rise_cnt - r0) + (fe_cnt - f0) + (ov_cnt - o0)), 32'd0);
    check("rst busy", 32'(bus.rx_busy), 32'h0);
    check("rst data", 32'(bus.rx_data), 32'h0);
    send_frame(8'h3C, 1'b1, 0, FRAME);
    rx_in = 1'b1;
    repeat (6) tick();
    check("rst next rises", 32'(rise_cnt - r0), 32'd1);
    check("rst next data", 32'(bus.rx_data), 32'h3C);
    flush();

`ifdef UART_RX_MAJORITY_EN
    // One-clock high glitch in the vote window of data bit 3
    r0 = rise_cnt; f0 = fe_cnt;
    send_frame(8'h00, 1'b1, HALF + CYCLE * 4, FRAME);
    rx_in = 1'b1;
    repeat (6) tick();
    check("maj rises", 32'(rise_cnt - r0), 32'd1);
    check("maj data", 32'(bus.rx_data), 32'h00);
    check("maj frame_err", 32'(fe_cnt - f0), 32'd0);
    flush();
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial receiver that sits directly downstream of the UART transmitter on the 8N1 link: 1 start bit, 8 data bits LSB first, 1 stop bit, idle line high.
- Synchronises the asynchronous line, finds the start bit, samples each bit near mid-bit, and delivers bytes through a valid/ack handshake.
- Reports framing errors and overruns.
- Same clock and baud constants as the transmitter, so the two blocks loop back directly.

Parameters:
- CLK_FRQ, 27000000, system clock frequency in Hz.
- BAUD_RATE, 921600, serial baud rate.
- CYCLE, CLK_FRQ/BAUD_RATE (integer division, 29 at defaults), clocks per bit. Derived localparam.
- HALF, CYCLE/2 (14 at defaults), start-bit verification point. Derived localparam.

Ports:
- clk  in  1  system clock, rising edge.
- reset  in  1  reset; synchronous, active-high (already decided).
- rx_in  in  1  asynchronous serial input; idle high.
- rx_data  out  8  received byte; stable while rx_valid=1.
- rx_valid  out  1  byte available; held until accepted.
- rx_ack  in  1  consumer accepts rx_data; meaningful only while rx_valid=1.
- rx_busy  out  1  high when state != S_IDLE.
- rx_frame_err  out  1  one-cycle pulse: stop bit sampled 0.
- rx_overrun  out  1  one-cycle pulse: a byte completed while rx_valid=1 and rx_ack=0.

Behaviour:
- Reset, synchronous, all state:
  - rx_data=0, rx_valid=0, rx_frame_err=0, rx_overrun=0, rx_busy=0, state=S_IDLE.
  - Counters cleared; both synchroniser flops =1.
  - Reset mid-frame abandons the frame; no pulse is generated.
- Synchroniser: two flops on rx_in; rx_s is the second flop. All decisions use rx_s, or the vote (see Optional Feature).
- Counters: cycle_cnt 16 bits, counts 0..CYCLE-1; bit_cnt 3 bits.
- States:
  - S_IDLE: when rx_s==0: go to S_START, cycle_cnt=0.
  - S_START: when cycle_cnt==HALF: if sample==0, go to S_DATA with cycle_cnt=0, bit_cnt=0; otherwise treat as a glitch and return to S_IDLE. Otherwise increment cycle_cnt.
  - S_DATA: when cycle_cnt==CYCLE-1: shift_reg <= {sample, shift_reg[7:1]} and cycle_cnt=0. If bit_cnt==7 go to S_STOP, else bit_cnt+1. Otherwise increment cycle_cnt.
  - S_STOP: when cycle_cnt==CYCLE-1:
    - sample==1: deliver the byte, go to S_IDLE.
    - sample==0: pulse rx_frame_err, discard the byte, go to S_BREAK.
  - S_BREAK: wait until rx_s==1, then go to S_IDLE. This prevents a held-low line from producing repeated frames.
- Delivery happens on the stop-sample edge:
  - rx_valid==0, or rx_ack==1 on the same edge: rx_data <= shift_reg, rx_valid <= 1, no overrun.
  - rx_valid==1 and rx_ack==0: rx_data keeps the old byte, the new byte is dropped, rx_overrun pulses one cycle.
- Handshake:
  - rx_ack with rx_valid=1 and no delivery on that edge: rx_valid <= 0 next edge.
  - rx_ack with rx_valid=0: ignored.
- Latency: number the first clk edge at which rx_in is sampled low as edge 1.
  - The decision for data bit i is made at edge 4+HALF+CYCLE*(i+1).
  - rx_valid is high after edge 4+HALF+9*CYCLE, which is 279 at defaults.
- Back-to-back frames: S_STOP returns to S_IDLE at mid-stop bit, so a start bit that follows immediately is detected. There are no dead cycles beyond the synchroniser.
- The receiver never stalls the line: decoding continues regardless of rx_valid.

Optional Feature:
- Macro: UART_RX_MAJORITY_EN.
- Defined: "sample" is the 2-of-3 majority of the last three rx_s values, held in a 3-bit history register that resets to 3'b111. Timing is unchanged. A single-cycle glitch at a decision point is rejected.
- Undefined: "sample" is rx_s directly. The history register is not built.

Decomposition:
- Package uart_pkg holds:
  - CLK_FRQ and BAUD_RATE defaults.
  - The CYCLE and HALF derivation.
  - Rx state encodings S_IDLE=0, S_START=1, S_DATA=2, S_STOP=3, S_BREAK=4 (3 bits).
- The transmitter's constants migrate into the same package.
- One sub-module is natural: sync_2ff, a 1-bit two-flop synchroniser with a reset value parameter (1 here).

Test Plan:
- Byte 8'h55, bits spaced exactly CYCLE clocks, rx_ack held 0 -> rx_valid rises after edge 279, rx_data=8'h55, no error pulses.
- Loopback from the transmitter, tx_data=8'hA3 then 8'h0F back-to-back, ack pulsed each time rx_valid=1 -> received 8'hA3 then 8'h0F, rx_overrun never asserts.
- Two frames 8'h12 then 8'h34 with rx_ack held 0 -> rx_data stays 8'h12, rx_overrun pulses exactly one cycle at the second stop sample.
- Frame 8'hFF with stop bit driven 0, line then held low for 5*CYCLE -> one rx_frame_err pulse, rx_valid stays 0, state S_BREAK until the line returns high, then 8'h81 is received correctly.
- rx_in low pulse of 5 clocks, then high -> S_START aborts at HALF, rx_valid=0, rx_busy returns to 0 by edge 4+HALF+1.
- reset asserted at bit 4 of 8'hC3, released, then 8'h3C sent -> no pulses during reset, 8'h3C received. With UART_RX_MAJORITY_EN: a 1-clock high glitch at a data-bit decision point of 8'h00 still yields 8'h00.
